// File: rtl/issue_packer_pkg.sv
// issue_packer_pkg: class codes, packet field offsets and RV32I opcodes shared by the issue packer.
package issue_packer_pkg;
    localparam int PKT_W     = 128;
    localparam int PC_LSB    = 96;
    localparam int INSTR_LSB = 64;
    localparam int IMM_LSB   = 32;
    localparam int RD_LSB    = 27;
    localparam int RS1_LSB   = 22;
    localparam int RS2_LSB   = 17;
    localparam int WE_BIT    = 16;
    localparam int CLS_LSB   = 13;
    localparam int SLOT_BIT  = 12;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd7
    } cls_e;

    typedef enum logic [1:0] {ST_EMPTY, ST_PAIR, ST_SECOND} state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
endpackage

// File: rtl/issue_packer_predecode.sv
// rv32_predecode: combinational RV32I pre-decode of one instruction into a 128-bit execute packet.
module rv32_predecode
    import issue_packer_pkg::*;
(
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    input  logic             slot,
    output logic [PKT_W-1:0] pkt
);
    cls_e        cls;
    logic [31:0] imm;
    logic        has_rd, use_rs1, use_rs2, rd_we;
    logic [4:0]  rd, rs1, rs2;

    always_comb begin
        cls     = CLS_ILLEGAL;
        imm     = '0;
        has_rd  = 1'b0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (instr[6:0])
            OPC_OP:     begin cls = CLS_ALU;    has_rd = 1'b1; use_rs2 = 1'b1; end
            OPC_OP_IMM: begin cls = CLS_ALU;    has_rd = 1'b1; imm = {{20{instr[31]}}, instr[31:20]}; end
            OPC_LOAD:   begin cls = CLS_LOAD;   has_rd = 1'b1; imm = {{20{instr[31]}}, instr[31:20]}; end
            OPC_STORE:  begin cls = CLS_STORE;  use_rs2 = 1'b1; imm = {{20{instr[31]}}, instr[31:25], instr[11:7]}; end
            OPC_BRANCH: begin cls = CLS_BRANCH; use_rs2 = 1'b1;
                              imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}; end
            OPC_LUI,
            OPC_AUIPC:  begin cls = CLS_ALU;    has_rd = 1'b1; use_rs1 = 1'b0; imm = {instr[31:12], 12'b0}; end
            OPC_JAL:    begin cls = CLS_JUMP;   has_rd = 1'b1; use_rs1 = 1'b0;
                              imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}; end
            OPC_JALR:   begin cls = CLS_JUMP;   has_rd = 1'b1; imm = {{20{instr[31]}}, instr[31:20]}; end
            default:    ;
        endcase
    end

    // rd is only meaningful for formats that carry a destination; stores/branches reuse those bits as imm
    assign rd    = has_rd ? instr[11:7] : 5'd0;
    assign rs1   = use_rs1 ? instr[19:15] : 5'd0;
    assign rs2   = use_rs2 ? instr[24:20] : 5'd0;
    assign rd_we = has_rd && (rd != 5'd0);
    assign pkt   = {pc, instr, imm, rd, rs1, rs2, rd_we, cls, slot, 12'b0};
endmodule

// File: rtl/issue_packer.sv
// issue_packer: holds one fetched instruction pair and issues it to the execute buffer
// as a single pair write or, on a hazard, as two consecutive single writes.
module issue_packer
    import issue_packer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [31:0]      fetch_pc,
    input  logic [31:0]      fetch_instr0,
    input  logic [31:0]      fetch_instr1,
    input  logic             buf_full,
    output logic             write1,
    output logic             write2,
    output logic [PKT_W-1:0] data1_out,
    output logic [PKT_W-1:0] data2_out
);
    state_e            state, state_nx;
    logic [31:0]       pc_q, instr0_q, instr1_q;
    logic [PKT_W-1:0]  p0, p1;
    logic              split, capture, go;
    logic [2:0]        c0, c1;
    logic [4:0]        rd0;

    rv32_predecode u_pd0 (.pc(pc_q),          .instr(instr0_q), .slot(1'b0), .pkt(p0));
    rv32_predecode u_pd1 (.pc(pc_q + 32'd4),  .instr(instr1_q), .slot(1'b1), .pkt(p1));

    assign c0  = p0[CLS_LSB +: 3];
    assign c1  = p1[CLS_LSB +: 3];
    assign rd0 = p0[RD_LSB +: 5];
    // unused rs fields decode to 0 and rd_we is clear for x0, so no false RAW match
    assign split = (p0[WE_BIT] && (p1[RS1_LSB +: 5] == rd0 || p1[RS2_LSB +: 5] == rd0))
                || ((c0 == CLS_LOAD || c0 == CLS_STORE) && (c1 == CLS_LOAD || c1 == CLS_STORE))
                || c0 == CLS_BRANCH || c0 == CLS_JUMP
                || c0 == CLS_ILLEGAL || c1 == CLS_ILLEGAL;

    assign go      = !flush && !buf_full;
    assign capture = fetch_valid && fetch_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            pc_q     <= '0;
            instr0_q <= '0;
            instr1_q <= '0;
        end else begin
            state <= state_nx;
            if (capture) begin
                pc_q     <= fetch_pc;
                instr0_q <= fetch_instr0;
                instr1_q <= fetch_instr1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = ST_EMPTY;
        else if (state == ST_EMPTY)
            state_nx = capture ? ST_PAIR : ST_EMPTY;
        else if (!buf_full)
            state_nx = (state == ST_PAIR && split) ? ST_SECOND : capture ? ST_PAIR : ST_EMPTY;
    end

    always_comb begin
        write2      = go && state == ST_PAIR && !split;
        write1      = go && ((state == ST_PAIR && split) || state == ST_SECOND);
        fetch_ready = !flush && (state == ST_EMPTY || write2 || (go && state == ST_SECOND));
        data1_out   = (write2 || (write1 && state == ST_PAIR)) ? p0 : write1 ? p1 : '0;
        data2_out   = write2 ? p1 : '0;
    end
endmodule
